// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry valid/ready pipeline stage (main + skid register).
// Latency 1 cycle; throughput 1 entry/cycle while out_ready=1.
// Backpressure: in_ready comes from registered state only (no out_ready path), so it drops once both entries are held.
//
// Ports:
//    clk, rst                     clock, asynchronous active-high reset
//    flush                        synchronous discard of all held entries
//    in_valid/in_ready/in_data    upstream handshake and payload
//    out_valid/out_ready/out_data downstream handshake and payload
//    stall_cnt                    saturating backpressure-cycle counter,
//                                 present only when PIPE_STAGE_PERF_EN is defined
//
// Optional feature macro: PIPE_STAGE_PERF_EN (adds stall_cnt and its counter).

module pipe_stage_skid #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef PIPE_STAGE_PERF_EN
   output logic [CNT_W-1:0] stall_cnt,
`endif
   output logic [WIDTH-1:0] out_data
);

   // State encoding is the pair of entry valid bits {skid_vld, main_vld}.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] main_dat;
   logic [WIDTH-1:0] skid_dat;
   logic             in_xfer;
   logic             out_xfer;

   // in_ready is held low during reset, otherwise only a function of state.
   assign in_ready  = (state != FULL) && !rst;
   assign out_valid = (state != EMPTY);
   assign out_data  = main_dat;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         main_dat <= '0;
         skid_dat <= '0;
      end else if (flush) begin
         // Flush wins over any same-cycle input; data registers keep their
         // contents so out_data stays at its last value while empty.
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  main_dat <= in_data;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (in_xfer && out_xfer) begin
                  main_dat <= in_data;
               end else if (in_xfer) begin
                  // Downstream stalled: park the new entry behind main.
                  skid_dat <= in_data;
                  state    <= FULL;
               end else if (out_xfer) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a pop can happen.
               if (out_xfer) begin
                  main_dat <= skid_dat;
                  state    <= BUSY;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   // Counts edges where an entry is offered but refused; saturates and is
   // cleared only by reset so flushes do not hide stall history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random stimulus for pipe_stage_skid,
// checked every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid;

   localparam int WIDTH = 32;
   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
`endif

   int tests = 0;
   int fails = 0;

   pipe_stage_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef PIPE_STAGE_PERF_EN
      .stall_cnt (stall_cnt),
`endif
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: a FIFO of at most two accepted entries ----------
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] last_dat = '0;
   int               m_cnt = 0;
   bit               m_ov;
   bit               m_ir;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         last_dat = '0;
         m_cnt    = 0;
      end else begin
         m_ov = (q.size() > 0);
         m_ir = (q.size() < 2);
         if (m_ov && !out_ready && m_cnt < CNT_MAX) m_cnt++;
         if (flush) begin
            q.delete();
         end else begin
            if (m_ov && out_ready) void'(q.pop_front());
            if (in_valid && m_ir) q.push_back(in_data);
         end
         if (q.size() > 0) last_dat = q[0];
      end
   end

   // ---------------- per-cycle compare on the falling edge ------------------
   always @(negedge clk) begin
      check("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
      check("in_ready", {63'd0, in_ready}, {63'd0, (!rst && q.size() < 2)});
      check("out_data", {32'd0, out_data}, {32'd0, last_dat});
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt", {62'd0, stall_cnt}, 64'(m_cnt));
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] vec[3];
      vec[0] = 32'h11; vec[1] = 32'h22; vec[2] = 32'h33;

      // Reset state
      #1 rst = 1'b1;
      #2;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_out_data", {32'd0, out_data}, 64'd0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Stream at full rate
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = vec[i];
         step();
         check("stream_data", {32'd0, out_data}, {32'd0, vec[i]});
         check("stream_valid", {63'd0, out_valid}, 64'd1);
         check("stream_in_ready", {63'd0, in_ready}, 64'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", {63'd0, out_valid}, 64'd0);

      // Backpressure fills the skid
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA;
      step();
      in_data = 32'hB;
      step();
      in_valid = 1'b0;
      check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_full_data", {32'd0, out_data}, 64'hA);
      step();
      check("bp_stable_data", {32'd0, out_data}, 64'hA);
      out_ready = 1'b1;
      step();
      check("bp_second_data", {32'd0, out_data}, 64'hB);
      check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
      step();
      check("bp_drained", {63'd0, out_valid}, 64'd0);

      // Flush overrides same-cycle input
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h5;
      step();
      check("fl_busy_data", {32'd0, out_data}, 64'h5);
      flush   = 1'b1;
      in_data = 32'h6;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_out_valid", {63'd0, out_valid}, 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("fl_no_6", {63'd0, out_valid}, 64'd0);
      end

      // Async reset while FULL
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h8;
      step();
      in_data = 32'h9;
      step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", {63'd0, out_valid}, 64'd0);
      check("arst_out_data", {32'd0, out_data}, 64'd0);
      rst = 1'b0;
      #1;
      check("arst_in_ready", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_data  = 32'h7;
      step();
      in_valid = 1'b0;
      check("arst_push_data", {32'd0, out_data}, 64'h7);
      check("arst_push_valid", {63'd0, out_valid}, 64'd1);

`ifdef PIPE_STAGE_PERF_EN
      // Saturating stall counter survives flush
      for (int i = 0; i < 5; i++) step();
      check("perf_sat", {62'd0, stall_cnt}, 64'd3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("perf_after_flush", {62'd0, stall_cnt}, 64'd3);
`endif

      // Random valid/ready/flush traffic
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 63) == 0);
         in_data   = $urandom;
         step();
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
